// File: rtl/dds_key_ctrl.sv
// Front-panel key decoder for the DDS generator: turns debounced key pulses into
// waveform selection, mute state and a saturating frequency tuning word.
module dds_key_ctrl #(
    parameter logic [23:0] CNT_DBL_MAX = 24'd9_999_999,
    parameter logic [31:0] FREQ_STEP   = 32'd85_899,
    parameter logic [31:0] FREQ_MIN    = 32'd85_899,
    parameter logic [31:0] FREQ_MAX    = 32'd858_993_459,
    parameter logic [31:0] FREQ_INIT   = 32'd85_899
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key0_flag,
    input  logic        key1_flag,
    input  logic        key2_flag,
    output logic [1:0]  wave_select,
    output logic        wave_en,
    output logic [31:0] freq_word,
    output logic        cfg_update
);

    typedef enum logic {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    // Saturation thresholds in 33 bits so neither the limit nor the step can wrap.
    localparam logic [32:0] UP_LIMIT = {1'b0, FREQ_MAX} - {1'b0, FREQ_STEP};
    localparam logic [32:0] DN_LIMIT = {1'b0, FREQ_MIN} + {1'b0, FREQ_STEP};

    state_t      state_reg, state_next;
    logic [23:0] cnt_dbl_reg, cnt_dbl_next;
    logic [1:0]  wave_select_reg, wave_select_next;
    logic        wave_en_reg, wave_en_next;
    logic [31:0] freq_word_reg, freq_word_next;
    logic        cfg_update_reg, cfg_update_next;
    logic        wave_evt;
    logic        freq_up;
    logic        freq_dn;

    assign freq_up = key1_flag & ~key2_flag;
    assign freq_dn = key2_flag & ~key1_flag;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            cnt_dbl_reg     <= '0;
            wave_select_reg <= 2'd0;
            wave_en_reg     <= 1'b1;
            freq_word_reg   <= FREQ_INIT;
            cfg_update_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_dbl_reg     <= cnt_dbl_next;
            wave_select_reg <= wave_select_next;
            wave_en_reg     <= wave_en_next;
            freq_word_reg   <= freq_word_next;
            cfg_update_reg  <= cfg_update_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_dbl_next     = cnt_dbl_reg;
        wave_select_next = wave_select_reg;
        wave_en_next     = wave_en_reg;
        wave_evt         = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_dbl_next = '0;
                if (key0_flag) begin
                    state_next = WAIT2;
                end
            end
            WAIT2: begin
                // A second press wins even on the last cycle of the window.
                if (key0_flag) begin
                    wave_en_next = ~wave_en_reg;
                    state_next   = IDLE;
                    cnt_dbl_next = '0;
                    wave_evt     = 1'b1;
                end else if (cnt_dbl_reg == CNT_DBL_MAX) begin
                    wave_select_next = wave_select_reg + 2'd1;
                    state_next       = IDLE;
                    cnt_dbl_next     = '0;
                    wave_evt         = 1'b1;
                end else begin
                    cnt_dbl_next = cnt_dbl_reg + 24'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_dbl_next = '0;
            end
        endcase
    end

    always_comb begin
        freq_word_next = freq_word_reg;
        if (freq_up) begin
            if ({1'b0, freq_word_reg} > UP_LIMIT) begin
                freq_word_next = FREQ_MAX;
            end else begin
                freq_word_next = freq_word_reg + FREQ_STEP;
            end
        end else if (freq_dn) begin
            if ({1'b0, freq_word_reg} < DN_LIMIT) begin
                freq_word_next = FREQ_MIN;
            end else begin
                freq_word_next = freq_word_reg - FREQ_STEP;
            end
        end
    end

    assign cfg_update_next = wave_evt | freq_up | freq_dn;

    assign wave_select = wave_select_reg;
    assign wave_en     = wave_en_reg;
    assign freq_word   = freq_word_reg;
    assign cfg_update  = cfg_update_reg;

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed and randomized check of dds_key_ctrl against a timestamp-based
// reference model of the key decoding rules.
module tb_dds_key_ctrl;

    localparam int DBL_MAX = 20;
    localparam int STEP    = 10;
    localparam int FMIN    = 10;
    localparam int FMAX    = 50;
    localparam int FINIT   = 10;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        key0_flag;
    logic        key1_flag;
    logic        key2_flag;
    logic [1:0]  wave_select;
    logic        wave_en;
    logic [31:0] freq_word;
    logic        cfg_update;

    dds_key_ctrl #(
        .CNT_DBL_MAX(24'(DBL_MAX)),
        .FREQ_STEP  (32'(STEP)),
        .FREQ_MIN   (32'(FMIN)),
        .FREQ_MAX   (32'(FMAX)),
        .FREQ_INIT  (32'(FINIT))
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key0_flag  (key0_flag),
        .key1_flag  (key1_flag),
        .key2_flag  (key2_flag),
        .wave_select(wave_select),
        .wave_en    (wave_en),
        .freq_word  (freq_word),
        .cfg_update (cfg_update)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;

    // Reference model: edge counter plus the edge index of a pending first press.
    longint     edge_cnt = 0;
    longint     pending  = -1;
    logic [1:0] m_sel    = 2'd0;
    logic       m_en     = 1'b1;
    longint     m_freq   = FINIT;
    logic       m_upd    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        pending = -1;
        m_sel   = 2'd0;
        m_en    = 1'b1;
        m_freq  = FINIT;
        m_upd   = 1'b0;
    endtask

    task automatic model_edge(input bit k0, input bit k1, input bit k2);
        edge_cnt++;
        m_upd = 1'b0;
        if (pending >= 0) begin
            if (k0) begin
                m_en    = ~m_en;
                pending = -1;
                m_upd   = 1'b1;
            end else if (edge_cnt - pending == DBL_MAX + 1) begin
                m_sel   = m_sel + 2'd1;
                pending = -1;
                m_upd   = 1'b1;
            end
        end else if (k0) begin
            pending = edge_cnt;
        end
        if (k1 && !k2) begin
            m_freq = (m_freq + STEP > FMAX) ? FMAX : m_freq + STEP;
            m_upd  = 1'b1;
        end else if (k2 && !k1) begin
            m_freq = (m_freq - STEP < FMIN) ? FMIN : m_freq - STEP;
            m_upd  = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sel"}, 32'(wave_select), 32'(m_sel));
        chk({tag, ".en"},  32'(wave_en),     32'(m_en));
        chk({tag, ".freq"}, freq_word,       32'(m_freq));
        chk({tag, ".upd"}, 32'(cfg_update),  32'(m_upd));
    endtask

    // Called at a negedge: drive flags for one edge, then check at the next negedge.
    task automatic tick(input bit k0, input bit k1, input bit k2, input string tag);
        key0_flag = k0;
        key1_flag = k1;
        key2_flag = k2;
        @(posedge sys_clk);
        model_edge(k0, k1, k2);
        @(negedge sys_clk);
        key0_flag = 1'b0;
        key1_flag = 1'b0;
        key2_flag = 1'b0;
        if (cfg_update === 1'b1) strobes++;
        check_model(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input int n);
        sys_rst_n = 1'b0;
        model_reset();
        repeat (n) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        chk("rst.sel",  32'(wave_select), 32'd0);
        chk("rst.en",   32'(wave_en),     32'd1);
        chk("rst.freq", freq_word,        32'(FINIT));
        chk("rst.upd",  32'(cfg_update),  32'd0);
    endtask

    int up_exp [6] = '{20, 30, 40, 50, 50, 50};
    int dn_exp [6] = '{40, 30, 20, 10, 10, 10};
    logic [1:0] sel_before;
    int s0;

    initial begin
        sys_rst_n = 1'b1;
        key0_flag = 1'b0;
        key1_flag = 1'b0;
        key2_flag = 1'b0;
        @(negedge sys_clk);
        do_reset(3);

        // Quiet period: no strobe at all.
        s0 = strobes;
        idle(100, "idle");
        chk("idle.strobes", 32'(strobes - s0), 32'd0);

        // Four single presses walk the waveform code through a full wrap.
        for (int p = 0; p < 4; p++) begin
            s0 = strobes;
            tick(1'b1, 1'b0, 1'b0, "single.press");
            idle(20, "single.wait");
            chk("single.early", 32'(wave_select), 32'(p % 4));
            tick(1'b0, 1'b0, 1'b0, "single.resolve");
            chk("single.sel", 32'(wave_select), 32'((p + 1) % 4));
            chk("single.strobes", 32'(strobes - s0), 32'd1);
        end

        // Second press on the last edge of the window is a double press.
        sel_before = wave_select;
        tick(1'b1, 1'b0, 1'b0, "double.first");
        idle(20, "double.wait");
        tick(1'b1, 1'b0, 1'b0, "double.second");
        chk("double.en", 32'(wave_en), 32'd0);
        chk("double.sel", 32'(wave_select), 32'(sel_before));
        idle(25, "double.after");

        // Second press one edge too late: single action, then a new window.
        tick(1'b1, 1'b0, 1'b0, "late.first");
        idle(20, "late.wait");
        tick(1'b0, 1'b0, 1'b0, "late.resolve");
        chk("late.sel", 32'(wave_select), 32'(sel_before + 2'd1));
        tick(1'b1, 1'b0, 1'b0, "late.second");
        idle(20, "late.wait2");
        tick(1'b0, 1'b0, 1'b0, "late.resolve2");
        chk("late.sel2", 32'(wave_select), 32'(sel_before + 2'd2));
        chk("late.en", 32'(wave_en), 32'd0);

        // Frequency saturation both ways, one strobe per press.
        s0 = strobes;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, "freq.up");
            chk("freq.up.val", freq_word, 32'(up_exp[i]));
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b1, "freq.dn");
            chk("freq.dn.val", freq_word, 32'(dn_exp[i]));
        end
        chk("freq.strobes", 32'(strobes - s0), 32'd12);

        // Both frequency keys together: nothing happens.
        tick(1'b0, 1'b1, 1'b1, "both");
        chk("both.freq", freq_word, 32'd10);
        chk("both.upd", 32'(cfg_update), 32'd0);

        // Frequency press on the same edge as a single-press resolution.
        sel_before = wave_select;
        s0 = strobes;
        tick(1'b1, 1'b0, 1'b0, "merge.press");
        idle(20, "merge.wait");
        tick(1'b0, 1'b1, 1'b0, "merge.resolve");
        chk("merge.sel", 32'(wave_select), 32'(sel_before + 2'd1));
        chk("merge.freq", freq_word, 32'd20);
        idle(3, "merge.after");
        chk("merge.strobes", 32'(strobes - s0), 32'd1);

        // Reset in the middle of a window discards the pending press.
        tick(1'b1, 1'b0, 1'b0, "rmid.press");
        idle(4, "rmid.pre");
        do_reset(3);
        s0 = strobes;
        idle(30, "rmid.post");
        chk("rmid.strobes", 32'(strobes - s0), 32'd0);
        tick(1'b1, 1'b0, 1'b0, "rmid.fresh");
        idle(20, "rmid.wait");
        tick(1'b0, 1'b0, 1'b0, "rmid.resolve");
        chk("rmid.sel", 32'(wave_select), 32'd1);

        // Randomized traffic with an occasional reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                tick($urandom_range(0, 14) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
